// File: rtl/score_counter_bcd.sv
// Multi-digit BCD score counter: serial digit-per-cycle add/subtract, saturate or wrap, active-low 7-seg drive.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits on leds.
module score_counter_bcd #(
  parameter int DIGITS = 2,
  parameter int WRAP   = 0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  clear,
  input  logic                  incValid,
  output logic                  incReady,
  input  logic                  incNeg,
  input  logic [4*DIGITS-1:0]   incAmount,
  output logic [4*DIGITS-1:0]   score,
  output logic [7*DIGITS-1:0]   leds,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            state;
  stateT            stateNext;
  logic [SW-1:0]    scoreReg;
  logic [SW-1:0]    workReg;
  logic [SW-1:0]    amtReg;
  logic             negReg;
  logic             carry;
  logic [IDX_W-1:0] digitIdx;
  logic             overflowReg;
  logic             underflowReg;

  logic [SW-1:0]    amtClamped;
  logic [3:0]       curScore;
  logic [3:0]       curAmt;
  logic [3:0]       calcDigit;
  logic             calcCarry;
  logic [SW-1:0]    commitValue;

  function automatic logic [3:0] clampDigit(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Returns {carryOut, digit}.
  function automatic logic [4:0] addDigit(input logic [3:0] a, input logic [3:0] b,
                                          input logic c);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b} + {4'b0000, c};
    if (sum > 5'd9) return {1'b1, 4'(sum - 5'd10)};
    return {1'b0, sum[3:0]};
  endfunction

  // Returns {borrowOut, digit}.
  function automatic logic [4:0] subDigit(input logic [3:0] a, input logic [3:0] b,
                                          input logic c);
    logic signed [5:0] diff;
    diff = $signed({2'b00, a}) - $signed({2'b00, b}) - $signed({5'b00000, c});
    if (diff < 0) begin
      diff = diff + 6'sd10;
      return {1'b1, diff[3:0]};
    end
    return {1'b0, diff[3:0]};
  endfunction

  // Segment order a..g from MSB to LSB, low = lit.
  function automatic logic [6:0] segDecode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  always_comb begin
    amtClamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      amtClamped[4*i +: 4] = clampDigit(incAmount[4*i +: 4]);
    end
  end

  always_comb begin
    curScore = scoreReg[4*digitIdx +: 4];
    curAmt   = amtReg[4*digitIdx +: 4];
    if (negReg) {calcCarry, calcDigit} = subDigit(curScore, curAmt, carry);
    else        {calcCarry, calcDigit} = addDigit(curScore, curAmt, carry);
  end

  // A final carry/borrow in saturating mode pins the score to the matching rail.
  always_comb begin
    commitValue = workReg;
    if (carry && (WRAP == 0)) begin
      commitValue = negReg ? '0 : {DIGITS{4'h9}};
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (incValid) stateNext = CALC;
      CALC:    if (digitIdx == LAST_IDX) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state        <= IDLE;
      scoreReg     <= '0;
      workReg      <= '0;
      amtReg       <= '0;
      negReg       <= 1'b0;
      carry        <= 1'b0;
      digitIdx     <= '0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      scoreReg     <= '0;
      carry        <= 1'b0;
      digitIdx     <= '0;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
    end else begin
      state        <= stateNext;
      overflowReg  <= 1'b0;
      underflowReg <= 1'b0;
      case (state)
        IDLE: begin
          if (incValid) begin
            amtReg   <= amtClamped;
            negReg   <= incNeg;
            carry    <= 1'b0;
            digitIdx <= '0;
          end
        end
        CALC: begin
          workReg[4*digitIdx +: 4] <= calcDigit;
          carry                    <= calcCarry;
          digitIdx                 <= digitIdx + 1'b1;
        end
        DONE: begin
          scoreReg     <= commitValue;
          overflowReg  <= carry & ~negReg;
          underflowReg <= carry & negReg;
        end
        default: ;
      endcase
    end
  end

  assign incReady  = (state == IDLE);
  assign score     = scoreReg;
  assign overflow  = overflowReg;
  assign underflow = underflowReg;

`ifdef LEADING_ZERO_BLANK_EN
  // Scan from the top digit down; stay blank until the first nonzero digit, digit 0 always shown.
  always_comb begin
    logic leading;
    leading = 1'b1;
    leds    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (scoreReg[4*i +: 4] != 4'd0) leading = 1'b0;
      if (leading && (i != 0)) leds[7*i +: 7] = 7'b1111111;
      else                     leds[7*i +: 7] = segDecode(scoreReg[4*i +: 4]);
    end
  end
`else
  always_comb begin
    leds = '0;
    for (int i = 0; i < DIGITS; i++) begin
      leds[7*i +: 7] = segDecode(scoreReg[4*i +: 4]);
    end
  end
`endif

endmodule

// File: tb/tb_score_counter_bcd.sv
// Bench for score_counter_bcd: two instances (saturating and wrapping) driven by the same stimulus,
// checked against an integer-valued model of the score.
module tb_score_counter_bcd;

  localparam int DIGITS = 2;
  localparam int SW     = 4 * DIGITS;
  localparam int LW     = 7 * DIGITS;
  localparam int MAXV   = 10 ** DIGITS - 1;

  logic          Clock;
  logic          Reset;
  logic          clear;
  logic          incValid;
  logic          incNeg;
  logic [SW-1:0] incAmount;
  logic          incReady0, incReady1;
  logic [SW-1:0] score0, score1;
  logic [LW-1:0] leds0, leds1;
  logic          overflow0, overflow1, underflow0, underflow1;

  int checks = 0;
  int errors = 0;
  int model0 = 0;
  int model1 = 0;

  logic [6:0] segTab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

  score_counter_bcd #(.DIGITS(DIGITS), .WRAP(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .clear(clear), .incValid(incValid), .incReady(incReady0),
    .incNeg(incNeg), .incAmount(incAmount), .score(score0), .leds(leds0),
    .overflow(overflow0), .underflow(underflow0));

  score_counter_bcd #(.DIGITS(DIGITS), .WRAP(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .clear(clear), .incValid(incValid), .incReady(incReady1),
    .incNeg(incNeg), .incAmount(incAmount), .score(score1), .leds(leds1),
    .overflow(overflow1), .underflow(underflow1));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic logic [SW-1:0] toBcd(input int v);
    logic [SW-1:0] b;
    b = '0;
    for (int i = 0; i < DIGITS; i++) begin
      b[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return b;
  endfunction

  function automatic int fromBcdClamped(input logic [SW-1:0] b);
    int v;
    int d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      v = v * 10 + d;
    end
    return v;
  endfunction

  function automatic logic [LW-1:0] ledsFor(input int v);
    logic [LW-1:0] l;
    for (int i = 0; i < DIGITS; i++) begin
      l[7*i +: 7] = segTab[(v / (10 ** i)) % 10];
`ifdef LEADING_ZERO_BLANK_EN
      if (i > 0 && v < 10 ** i) l[7*i +: 7] = 7'b1111111;
`endif
    end
    return l;
  endfunction

  function automatic void modelStep(input int s, input int a, input bit neg, input bit wrap,
                                    output int r, output bit flag);
    int v;
    v    = neg ? s - a : s + a;
    flag = 1'b0;
    r    = v;
    if (v > MAXV) begin
      flag = 1'b1;
      r    = wrap ? v - (MAXV + 1) : MAXV;
    end else if (v < 0) begin
      flag = 1'b1;
      r    = wrap ? v + (MAXV + 1) : 0;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, "_score0"}, score0, toBcd(model0));
    check({tag, "_score1"}, score1, toBcd(model1));
    check({tag, "_leds0"}, leds0, ledsFor(model0));
    check({tag, "_leds1"}, leds1, ledsFor(model1));
    check({tag, "_ready"}, {incReady0, incReady1}, 2'b11);
    check({tag, "_flags"}, {overflow0, underflow0, overflow1, underflow1}, 4'b0000);
  endtask

  // Full accept..commit sequence with per-cycle checks; holdValid keeps junk requests asserted while busy.
  task automatic runStep(input bit neg, input logic [SW-1:0] amt, input bit holdValid);
    int  a, r0, r1;
    bit  f0, f1;
    a = fromBcdClamped(amt);
    modelStep(model0, a, neg, 1'b0, r0, f0);
    modelStep(model1, a, neg, 1'b1, r1, f1);
    @(negedge Clock);
    incValid  = 1'b1;
    incNeg    = neg;
    incAmount = amt;
    for (int k = 0; k <= DIGITS; k++) begin
      @(negedge Clock);
      if (holdValid) begin
        incNeg    = 1'($urandom_range(0, 1));
        incAmount = SW'($urandom);
      end else begin
        incValid = 1'b0;
      end
      check("busy_ready", {incReady0, incReady1}, 2'b00);
      check("busy_score0", score0, toBcd(model0));
      check("busy_score1", score1, toBcd(model1));
      check("busy_flags", {overflow0, underflow0, overflow1, underflow1}, 4'b0000);
    end
    @(negedge Clock);
    incValid = 1'b0;
    model0 = r0;
    model1 = r1;
    check("commit_score0", score0, toBcd(model0));
    check("commit_score1", score1, toBcd(model1));
    check("commit_leds0", leds0, ledsFor(model0));
    check("commit_leds1", leds1, ledsFor(model1));
    check("commit_flags0", {overflow0, underflow0}, {f0 & ~neg, f0 & neg});
    check("commit_flags1", {overflow1, underflow1}, {f1 & ~neg, f1 & neg});
    @(negedge Clock);
    checkIdle("after_commit");
  endtask

  task automatic doClear();
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    clear  = 1'b0;
    model0 = 0;
    model1 = 0;
    checkIdle("clear");
  endtask

  initial begin
    logic [SW-1:0] amt;
    Reset     = 1'b0;
    clear     = 1'b0;
    incValid  = 1'b0;
    incNeg    = 1'b0;
    incAmount = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    checkIdle("reset");
    check("reset_leds_const", leds0, {DIGITS{7'b0000001}});

    // Reset asserted for one edge in the middle of a calculation.
    @(negedge Clock);
    incValid = 1'b1; incNeg = 1'b0; incAmount = 8'h45;
    @(negedge Clock);
    incValid = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    checkIdle("mid_reset");
    @(negedge Clock);
    checkIdle("mid_reset_noflag");
    runStep(1'b0, 8'h12, 1'b0);
    check("post_reset_12", score0, 8'h12);

    // 08 + 02 ripples a carry into the tens digit.
    doClear();
    runStep(1'b0, 8'h08, 1'b0);
    runStep(1'b0, 8'h02, 1'b1);
    check("carry_10", score0, 8'h10);
    check("carry_10_leds", leds0, ledsFor(10));

    // 01 - 02 underflows.
    doClear();
    runStep(1'b0, 8'h01, 1'b0);
    runStep(1'b1, 8'h02, 1'b0);
    check("unf_sat", score0, 8'h00);
    check("unf_wrap", score1, 8'h99);

    // 98 + 05 overflows.
    doClear();
    runStep(1'b0, 8'h98, 1'b0);
    runStep(1'b0, 8'h05, 1'b0);
    check("ovf_sat", score0, 8'h99);
    check("ovf_wrap", score1, 8'h03);

    // Zero step, digit clamping, and saturation rails.
    runStep(1'b0, 8'h00, 1'b0);
    runStep(1'b1, 8'h00, 1'b0);
    runStep(1'b0, 8'hFF, 1'b0);
    runStep(1'b1, 8'hFA, 1'b1);

    // Clear at E1 while incValid held.
    doClear();
    runStep(1'b0, 8'h20, 1'b0);
    @(negedge Clock);
    incValid = 1'b1; incNeg = 1'b0; incAmount = 8'h11;
    @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    clear    = 1'b0;
    incValid = 1'b0;
    model0   = 0;
    model1   = 0;
    checkIdle("clear_busy");
    @(negedge Clock);
    checkIdle("clear_busy_noflag");
    @(negedge Clock);
    checkIdle("clear_busy_hold");

    runStep(1'b0, 8'h05, 1'b0);

    // Randomized walk.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 11) == 0) begin
        doClear();
      end else begin
        for (int i = 0; i < DIGITS; i++) begin
          amt[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        end
        runStep(1'($urandom_range(0, 1)), amt, 1'($urandom_range(0, 1)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
